bram_sdp: RTL and testbench
===========================

Name: bram_sdp

Overview:
- Parametrised simple-dual-port block RAM: one write port with byte enables, one read port, synchronous read with 1 or 2 cycles of latency, and a `r_valid` strobe.
- Replaces single-cycle combinational-read memories in the rv32i_sc core.
- Used for both instruction and data memory.
- Reset clears the array sequentially through a clear state machine, one word per cycle, so the array maps onto real BRAM.

Parameters:
- DATA_WIDTH, 32: word width in bits. Must be a multiple of 8.
- DEPTH, 1024: number of words. Must be a power of two.
- RD_LATENCY, 1: read latency in cycles. Legal values are 1 (array output) and 2 (array output plus output register).
- WRITE_FIRST, 0: selects the same-address read/write collision rule. 0 = read-first (old data), 1 = write-first (new merged data).
- Derived constants:
  - NB_BYTES = DATA_WIDTH/8
  - WA = $clog2(DEPTH)
  - BA = WA + $clog2(NB_BYTES), the byte-address width

Ports:
- clk  in  1  Clock.
- rst  in  1  Synchronous reset, active-high. Starts the array clear.
- w_addr  in  BA  Write byte address. The low $clog2(NB_BYTES) bits are ignored.
- w_dat  in  DATA_WIDTH  Write data.
- w_enb  in  NB_BYTES  Byte write mask. Bit k writes w_dat[8k+7:8k]. All zeros means no write.
- r_addr  in  BA  Read byte address. The low bits are ignored.
- r_enb  in  1  Read request.
- r_dat  out  DATA_WIDTH  Read data. Holds its last value until the next valid read.
- r_valid  out  1  One-cycle pulse; r_dat is valid in the same cycle.
- busy  out  1  High while the clear is in progress. Requests are ignored while busy is high.
- debug_addr  in  BA  Debug word-read address.
- debug_data  out  DATA_WIDTH  Registered debug read. Latency 1, always active, read-first.

Behaviour:
- Reset: all outputs are synchronous.
  - The cycle after rst is sampled high: busy=1, r_valid=0, r_dat=0, debug_data=0, clear counter=0.
  - Any pipeline stage holding a read is killed.
- FSM states: CLEAR and RUN.
  - CLEAR: write 0 to mem[cnt] each cycle and increment cnt. When cnt reaches DEPTH-1, that word is written and the state moves to RUN.
  - The clear takes exactly DEPTH cycles after rst deasserts; busy drops in the cycle after the last write.
  - rst asserted in any state, including mid-CLEAR, restarts CLEAR at cnt=0.
- Reads and writes issued while busy=1 are dropped silently. They produce no r_valid and no array change.
- RUN, write: each word lane is updated independently according to w_enb. Any mask pattern is legal, including sparse masks such as 4'b0101.
- RUN, read: a read issued in cycle N gives r_valid=1 and r_dat=mem[r_addr[BA-1:BA-WA]] in cycle N+RD_LATENCY.
  - Back-to-back reads are fully pipelined, one per cycle.
- Read and write are independent. Both ports may be active in the same cycle.
- Collision (same word, same cycle):
  - WRITE_FIRST=0: read returns the pre-write word.
  - WRITE_FIRST=1: read returns the merged word, i.e. the old bytes with the enabled bytes replaced.
  - Disabled bytes always return old data.
- A write to address X in cycle N followed by a read of X in cycle N+1 returns the new data in both modes.
- Address wrap: no range check is needed because DEPTH is a power of two. Only the word-index bits are used.
- r_dat is not zeroed between reads. Consumers must qualify it with r_valid.
- debug_data reads the array every cycle, including during CLEAR, where it shows words that are partially cleared.

Decomposition:
- Shared package (rv32i_params.vh):
  - DATA_WIDTH, BYTES_PER_WORD, I_BRAM_DEPTH, D_BRAM_DEPTH.
  - Collision-mode constants BRAM_READ_FIRST and BRAM_WRITE_FIRST.
  - FSM state encodings BRAM_ST_CLEAR and BRAM_ST_RUN.
- One natural sub-module: bram_byte_merge, combinational. Inputs old word, w_dat and w_enb; output merged word. Used by both the write path and the write-first bypass.
- The clear counter and FSM stay in the top module.

Test Plan:
- Clear: DEPTH=16. Pre-load 0xDEADBEEF through backdoor, pulse rst for 1 cycle.
  - busy stays high for exactly 16 cycles.
  - Reads of every word then return 0x00000000.
  - A read issued while busy=1 produces no r_valid.
- Byte mask: write 0x11223344 to 0x08 with w_enb=1111, then 0xAABBCCDD with w_enb=0101.
  - A read of 0x08 (and of 0x0A) returns 0x11BB33DD.
- Latency: RD_LATENCY=1 and =2. Run reads of 0x00, 0x04, 0x08 in consecutive cycles.
  - r_valid goes high in cycles N+L, N+L+1, N+L+2.
  - Data arrives in order, and r_dat holds its value after the last pulse.
- Collision: mem[0x10]=0x00000000. Same cycle: write 0xCAFEF00D with w_enb=0011, read 0x10.
  - WRITE_FIRST=0 returns 0x00000000.
  - WRITE_FIRST=1 returns 0x0000F00D.
  - A read in the next cycle returns 0x0000F00D in both modes.
- Reset mid-clear: assert rst at clear cycle 7 with DEPTH=16.
  - busy stays high for 16 cycles from the new rst release.
  - No read issued in that window produces r_valid.
- Wrap: DEPTH=16. Write to byte address 0x3C, read 0x3C and 0x3F.
  - Both reads return the written word.
  - debug_addr=0x3C gives debug_data equal to the same word one cycle later.

Source files
------------

// File: rtl/bram_sdp_pkg.sv
// Shared constants for the rv32i_sc block RAMs: default geometry,
// collision-mode selectors and the clear/run state encoding.
package bram_sdp_pkg;

   localparam int BRAM_DATA_WIDTH     = 32;
   localparam int BRAM_BYTES_PER_WORD = BRAM_DATA_WIDTH / 8;
   localparam int I_BRAM_DEPTH        = 1024;
   localparam int D_BRAM_DEPTH        = 1024;

   localparam int BRAM_READ_FIRST  = 0;
   localparam int BRAM_WRITE_FIRST = 1;

   typedef enum logic {
      BRAM_ST_CLEAR = 1'b0,
      BRAM_ST_RUN   = 1'b1
   } bram_state_e;

endpackage

// File: rtl/bram_sdp_byte_merge.sv
// Replaces the enabled byte lanes of an old word with the matching lanes
// of the write data; shared by the array write path and write-first bypass.
module bram_byte_merge
   import bram_sdp_pkg::*;
#(
   parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
   localparam int NB_BYTES  = DATA_WIDTH / 8
) (
   input  logic [DATA_WIDTH-1:0] old_word,
   input  logic [DATA_WIDTH-1:0] w_dat,
   input  logic [NB_BYTES-1:0]   w_enb,
   output logic [DATA_WIDTH-1:0] merged
);

   always_comb begin
      merged = old_word;
      for (int k = 0; k < NB_BYTES; k++) begin
         if (w_enb[k]) begin
            merged[8*k +: 8] = w_dat[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port block RAM with byte-masked writes, 1- or 2-cycle read
// latency and a sequential one-word-per-cycle clear after reset.
module bram_sdp
   import bram_sdp_pkg::*;
#(
   parameter int DATA_WIDTH  = BRAM_DATA_WIDTH,
   parameter int DEPTH       = D_BRAM_DEPTH,
   parameter int RD_LATENCY  = 1,
   parameter int WRITE_FIRST = BRAM_READ_FIRST,
   localparam int NB_BYTES   = DATA_WIDTH / 8,
   localparam int WA         = $clog2(DEPTH),
   localparam int BA         = WA + $clog2(NB_BYTES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BA-1:0]         w_addr,
   input  logic [DATA_WIDTH-1:0] w_dat,
   input  logic [NB_BYTES-1:0]   w_enb,
   input  logic [BA-1:0]         r_addr,
   input  logic                  r_enb,
   output logic [DATA_WIDTH-1:0] r_dat,
   output logic                  r_valid,
   output logic                  busy,
   input  logic [BA-1:0]         debug_addr,
   output logic [DATA_WIDTH-1:0] debug_data
);

   localparam logic [WA-1:0] LAST_WORD = WA'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   bram_state_e           state, state_next;
   logic [WA-1:0]         cnt, cnt_next;
   logic                  clr_we;
   logic                  run;

   logic [WA-1:0]         w_word, r_word, debug_word;
   logic [DATA_WIDTH-1:0] merged_word;
   logic                  wr_req, rd_req, collide;

   logic                  mem_we;
   logic [WA-1:0]         mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] rd_word_data;

   logic                  v1;
   logic [DATA_WIDTH-1:0] d1;

   assign w_word     = w_addr[BA-1 -: WA];
   assign r_word     = r_addr[BA-1 -: WA];
   assign debug_word = debug_addr[BA-1 -: WA];

   if (BA > WA) begin : g_lsb
      logic unused_lsbs;
      assign unused_lsbs = ^{w_addr[BA-WA-1:0], r_addr[BA-WA-1:0], debug_addr[BA-WA-1:0]};
   end

   assign run  = (state == BRAM_ST_RUN);
   assign busy = ~run;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BRAM_ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      clr_we     = 1'b0;
      case (state)
         BRAM_ST_CLEAR: begin
            clr_we   = 1'b1;
            cnt_next = cnt + 1'b1;
            if (cnt == LAST_WORD) begin
               state_next = BRAM_ST_RUN;
            end
         end
         default: ;
      endcase
   end

   bram_byte_merge #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_merge (
      .old_word (mem[w_word]),
      .w_dat    (w_dat),
      .w_enb    (w_enb),
      .merged   (merged_word)
   );

   assign wr_req = run & ~rst & (|w_enb);
   assign rd_req = run & ~rst & r_enb;

   // The clear owns the single write port while busy; user writes are dropped.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = w_word;
      mem_data = merged_word;
      if (clr_we && !rst) begin
         mem_we   = 1'b1;
         mem_addr = cnt;
         mem_data = '0;
      end else if (wr_req) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_data;
      end
   end

   assign collide      = (WRITE_FIRST == BRAM_WRITE_FIRST) && wr_req && (w_word == r_word);
   assign rd_word_data = collide ? merged_word : mem[r_word];

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= rd_req;
         if (rd_req) begin
            d1 <= rd_word_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         debug_data <= '0;
      end else begin
         debug_data <= mem[debug_word];
      end
   end

   if (RD_LATENCY == 2) begin : g_outreg
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;

      always_ff @(posedge clk) begin
         if (rst) begin
            v2 <= 1'b0;
            d2 <= '0;
         end else begin
            v2 <= v1;
            if (v1) begin
               d2 <= d1;
            end
         end
      end

      assign r_valid = v2;
      assign r_dat   = d2;
   end else begin : g_direct
      assign r_valid = v1;
      assign r_dat   = d1;
   end

endmodule

// File: tb/tb_bram_sdp.sv
// Runs four bram_sdp variants (latency 1/2 x read-first/write-first) in
// lockstep against a word-array reference model with a pending-read queue.
module tb_bram_sdp;

   localparam int DW    = 32;
   localparam int NB    = DW / 8;
   localparam int DEPTH = 16;
   localparam int BA    = 6;
   localparam int NINST = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [BA-1:0] w_addr, r_addr, debug_addr;
   logic [DW-1:0] w_dat;
   logic [NB-1:0] w_enb;
   logic          r_enb;

   logic [DW-1:0] r_dat_o   [NINST];
   logic          r_valid_o [NINST];
   logic          busy_o    [NINST];
   logic [DW-1:0] debug_o   [NINST];

   always #5 clk = ~clk;

   // Instance g: latency (g%2)+1, write-first when g>=2.
   for (genvar g = 0; g < NINST; g++) begin : g_dut
      bram_sdp #(
         .DATA_WIDTH  (DW),
         .DEPTH       (DEPTH),
         .RD_LATENCY  ((g % 2) + 1),
         .WRITE_FIRST (g / 2)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .w_addr     (w_addr),
         .w_dat      (w_dat),
         .w_enb      (w_enb),
         .r_addr     (r_addr),
         .r_enb      (r_enb),
         .r_dat      (r_dat_o[g]),
         .r_valid    (r_valid_o[g]),
         .busy       (busy_o[g]),
         .debug_addr (debug_addr),
         .debug_data (debug_o[g])
      );
   end

   typedef struct {
      int            inst;
      int            due;
      logic [DW-1:0] d;
   } rd_t;

   logic [DW-1:0] model_mem [DEPTH];
   bit            known     [DEPTH];
   rd_t           pend[$];
   logic [DW-1:0] exp_dat   [NINST];
   bit            exp_valid [NINST];
   logic [DW-1:0] exp_debug;
   bit            debug_known;
   int            clear_rem;
   int            cyc;
   int            total, bad;

   function automatic logic [DW-1:0] mergeBytes(logic [DW-1:0] old, logic [DW-1:0] nw,
                                                logic [NB-1:0] en);
      logic [DW-1:0] r;
      r = old;
      for (int k = 0; k < NB; k++) begin
         if (en[k]) r[8*k +: 8] = nw[8*k +: 8];
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Applies the effect of one clock edge using the inputs held across it.
   task automatic modelEdge();
      int            ww, rw, dw;
      bit            busy_before;
      logic [DW-1:0] old, wf;
      ww = int'(w_addr[BA-1:2]);
      rw = int'(r_addr[BA-1:2]);
      dw = int'(debug_addr[BA-1:2]);
      if (rst) begin
         pend.delete();
         for (int i = 0; i < NINST; i++) begin
            exp_dat[i]   = '0;
            exp_valid[i] = 1'b0;
         end
         clear_rem   = DEPTH;
         exp_debug   = '0;
         debug_known = 1'b1;
      end else begin
         busy_before = (clear_rem > 0);
         exp_debug   = model_mem[dw];
         debug_known = known[dw];
         if (!busy_before && r_enb) begin
            old = model_mem[rw];
            wf  = (w_enb != '0 && ww == rw) ? mergeBytes(old, w_dat, w_enb) : old;
            for (int i = 0; i < NINST; i++) begin
               pend.push_back('{inst: i, due: cyc + (i % 2), d: (i / 2 == 1) ? wf : old});
            end
         end
         if (!busy_before && w_enb != '0) begin
            model_mem[ww] = mergeBytes(model_mem[ww], w_dat, w_enb);
            if (w_enb == '1) known[ww] = 1'b1;
         end
         if (busy_before) begin
            model_mem[DEPTH - clear_rem] = '0;
            known[DEPTH - clear_rem]     = 1'b1;
            clear_rem--;
         end
         for (int i = 0; i < NINST; i++) exp_valid[i] = 1'b0;
         for (int j = pend.size() - 1; j >= 0; j--) begin
            if (pend[j].due == cyc) begin
               exp_valid[pend[j].inst] = 1'b1;
               exp_dat[pend[j].inst]   = pend[j].d;
               pend.delete(j);
            end
         end
      end
   endtask

   task automatic checkCycle();
      for (int i = 0; i < NINST; i++) begin
         checkOutput($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(clear_rem > 0));
         checkOutput($sformatf("rvalid%0d", i), 32'(r_valid_o[i]), 32'(exp_valid[i]));
         checkOutput($sformatf("rdat%0d", i), r_dat_o[i], exp_dat[i]);
         if (debug_known) checkOutput($sformatf("debug%0d", i), debug_o[i], exp_debug);
      end
   endtask

   task automatic applyStimulus(input logic rst_i, input logic [BA-1:0] wa, input logic [DW-1:0] wd,
                                input logic [NB-1:0] we, input logic [BA-1:0] ra, input logic re,
                                input logic [BA-1:0] da);
      rst        = rst_i;
      w_addr     = wa;
      w_dat      = wd;
      w_enb      = we;
      r_addr     = ra;
      r_enb      = re;
      debug_addr = da;
      @(posedge clk);
      cyc++;
      modelEdge();
      #1;
      checkCycle();
   endtask

   // Steps with random (to-be-dropped) traffic until busy falls; returns busy length.
   task automatic runClear(output int n);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         if (!busy_o[0]) break;
         n++;
         applyStimulus(1'b0, BA'($urandom), $urandom, NB'($urandom), BA'($urandom), 1'b1,
                       BA'($urandom));
      end
   endtask

   int            n;
   logic [DW-1:0] wrap_word;

   initial begin
      total     = 0;
      bad       = 0;
      cyc       = 0;
      clear_rem = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = '0;
         known[i]     = 1'b0;
      end
      for (int i = 0; i < NINST; i++) begin
         exp_dat[i]   = '0;
         exp_valid[i] = 1'b0;
      end

      applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0);
      runClear(n);
      checkOutput("busy_len_init", 32'(n), 32'd16);

      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b0, BA'(i * 4), 32'hDEADBEEF, 4'hF, '0, 1'b0, BA'(i * 4));
      applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0);
      runClear(n);
      checkOutput("busy_len_clear", 32'(n), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, '0, '0, '0, BA'(i * 4), 1'b1, BA'(i * 4));
         checkOutput("clear_rd", r_dat_o[0], 32'h0);
      end

      applyStimulus(1'b0, 6'h08, 32'h11223344, 4'b1111, '0, 1'b0, '0);
      applyStimulus(1'b0, 6'h08, 32'hAABBCCDD, 4'b0101, '0, 1'b0, '0);
      applyStimulus(1'b0, '0, '0, '0, 6'h08, 1'b1, '0);
      checkOutput("mask_08", r_dat_o[0], 32'h11BB33DD);
      applyStimulus(1'b0, '0, '0, '0, 6'h0A, 1'b1, '0);
      checkOutput("mask_0A", r_dat_o[0], 32'h11BB33DD);

      applyStimulus(1'b0, '0, '0, '0, 6'h00, 1'b1, '0);
      applyStimulus(1'b0, '0, '0, '0, 6'h04, 1'b1, '0);
      applyStimulus(1'b0, '0, '0, '0, 6'h08, 1'b1, '0);
      checkOutput("lat1_last", r_dat_o[0], 32'h11BB33DD);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0);
      checkOutput("hold_l2", r_dat_o[1], 32'h11BB33DD);
      checkOutput("hold_valid_l2", 32'(r_valid_o[1]), 32'd0);

      applyStimulus(1'b0, 6'h10, 32'hCAFEF00D, 4'b0011, 6'h10, 1'b1, '0);
      checkOutput("coll_rf", r_dat_o[0], 32'h00000000);
      checkOutput("coll_wf", r_dat_o[2], 32'h0000F00D);
      applyStimulus(1'b0, '0, '0, '0, 6'h10, 1'b1, '0);
      checkOutput("after_rf", r_dat_o[0], 32'h0000F00D);
      checkOutput("after_wf", r_dat_o[2], 32'h0000F00D);
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0);

      applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0);
      for (int i = 0; i < 7; i++)
         applyStimulus(1'b0, BA'($urandom), $urandom, 4'hF, BA'($urandom), 1'b1, '0);
      applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0);
      runClear(n);
      checkOutput("busy_len_midclr", 32'(n), 32'd16);

      wrap_word = $urandom;
      applyStimulus(1'b0, 6'h3C, wrap_word, 4'hF, '0, 1'b0, '0);
      applyStimulus(1'b0, '0, '0, '0, 6'h3C, 1'b1, 6'h3C);
      checkOutput("wrap_3C", r_dat_o[0], wrap_word);
      checkOutput("wrap_debug", debug_o[0], wrap_word);
      applyStimulus(1'b0, '0, '0, '0, 6'h3F, 1'b1, '0);
      checkOutput("wrap_3F", r_dat_o[0], wrap_word);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0), BA'($urandom), $urandom, NB'($urandom),
                       BA'($urandom), 1'($urandom), BA'($urandom));
      end
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, BA'(i * 4));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
